// File: rtl/uparc_fetch.sv
// ----------------------------------------------------------------------------
// uparc_fetch
//
// Instruction fetch stage, sitting directly upstream of decode.  It owns the
// fetch PC, issues single-word reads on the instruction bus with at most one
// transaction outstanding, and keeps one fetched word in an output buffer.
// Decode sees that word together with its PC.  Jumps from execute and
// exception vectors from the CU redirect the fetch PC and flush the buffer.
//
// Configuration macro:
//   UPARC_FETCH_ALIGN_CHECK_EN
//     defined   : a misaligned redirect target issues no bus read. Instead a
//                 NOP is presented with o_fetch_err=1 and o_pc=target, and the
//                 fetch PC holds until the next redirect.
//     undefined : the low two bits of a redirect target are cleared and the
//                 word is fetched normally.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_exec_stall      execute stage stalled
//   i_mem_stall       memory stage stalled
//   i_jump_valid      taken jump/branch from execute (one-cycle pulse)
//   i_jump_addr       jump target
//   i_except_start    exception redirect from the CU (one-cycle pulse)
//   i_except_addr     exception vector
//   o_bus_req         instruction bus read request
//   o_bus_addr        word-aligned read address
//   i_bus_ack         request accepted, data valid this cycle
//   i_bus_data        instruction word
//   i_bus_err         bus error, qualified by i_bus_ack
//   o_instr           buffered instruction for decode
//   o_pc              PC of o_instr
//   o_fetch_stall     no valid instruction available
//   o_fetch_err       o_instr came from an erroring fetch
// ----------------------------------------------------------------------------
module uparc_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_exec_stall,
    input  logic        i_mem_stall,
    input  logic        i_jump_valid,
    input  logic [31:0] i_jump_addr,
    input  logic        i_except_start,
    input  logic [31:0] i_except_addr,
    output logic        o_bus_req,
    output logic [31:0] o_bus_addr,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_data,
    input  logic        i_bus_err,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_fetch_stall,
    output logic        o_fetch_err
);

    logic        r_rst_q;
    logic [31:0] r_fetch_pc;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic        r_err;
    logic        r_discard;

    logic        w_consume;
    logic        w_redirect;
    logic        w_req;
    logic        w_ack;
    logic [31:0] w_target;

    // Decode latches the buffered word on the same edge it is consumed.
    assign w_consume  = r_valid && !i_exec_stall && !i_mem_stall;
    assign w_redirect = i_except_start || i_jump_valid;

`ifdef UPARC_FETCH_ALIGN_CHECK_EN
    logic r_align_pend;
    logic r_align_hold;
    logic w_target_misaligned;

    // Exception wins over a jump in the same cycle.
    assign w_target            = i_except_start ? i_except_addr : i_jump_addr;
    assign w_target_misaligned = (w_target[1:0] != 2'b00);

    // A misaligned target blocks new requests, but a read already presented
    // before the redirect is kept asserted until the fabric acks it.
    assign w_req = !r_rst_q &&
                   (r_discard ||
                    ((!r_valid || w_consume) && !r_align_pend && !r_align_hold));
`else
    // Exception wins over a jump; the target is forced onto a word boundary.
    assign w_target = (i_except_start ? i_except_addr : i_jump_addr) & 32'hFFFF_FFFC;

    // The buffer is empty (or being emptied) whenever a read is requested, so
    // valid stays low while a request waits and the address cannot move.
    assign w_req = !r_rst_q && (!r_valid || w_consume);
`endif

    assign w_ack = i_bus_ack && w_req;

    assign o_bus_req     = w_req;
    assign o_bus_addr    = {r_fetch_pc[31:2], 2'b00};
    assign o_instr       = r_instr;
    assign o_pc          = r_pc;
    assign o_fetch_stall = !r_valid;
    assign o_fetch_err   = r_err;

    // Fetch PC, output buffer and discard tracking.  A redirect flushes the
    // buffer; if a read is still waiting for its ack, that ack's data belongs
    // to the old path and is thrown away when it arrives.
    always_ff @(posedge clk) begin
        r_rst_q <= rst;
        if (rst) begin
            r_fetch_pc <= RESET_ADDR;
            r_valid    <= 1'b0;
            r_instr    <= 32'h0;
            r_pc       <= 32'h0;
            r_err      <= 1'b0;
            r_discard  <= 1'b0;
`ifdef UPARC_FETCH_ALIGN_CHECK_EN
            r_align_pend <= 1'b0;
            r_align_hold <= 1'b0;
`endif
        end else if (w_redirect) begin
            // An ack in the redirect cycle is simply dropped; an unacked
            // request leaves one stale ack still to come.
            r_fetch_pc <= w_target;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_discard  <= w_req && !i_bus_ack;
`ifdef UPARC_FETCH_ALIGN_CHECK_EN
            r_align_pend <= w_target_misaligned;
            r_align_hold <= 1'b0;
`endif
        end else begin
            if (w_ack && r_discard) begin
                r_discard <= 1'b0;
            end else if (w_ack) begin
                // An errored word goes to decode as a NOP, flagged for the CU.
                r_instr    <= i_bus_err ? 32'h0 : i_bus_data;
                r_pc       <= r_fetch_pc;
                r_err      <= i_bus_err;
                r_valid    <= 1'b1;
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end
`ifdef UPARC_FETCH_ALIGN_CHECK_EN
            // One cycle after a misaligned redirect, present the faulting PC
            // as an errored NOP and stop fetching until the next redirect.
            if (r_align_pend) begin
                r_valid      <= 1'b1;
                r_instr      <= 32'h0;
                r_pc         <= r_fetch_pc;
                r_err        <= 1'b1;
                r_align_pend <= 1'b0;
                r_align_hold <= 1'b1;
            end
`endif
        end
    end

endmodule
